// File: rtl/regfile_pkg.sv
// Shared defaults and read-bus packing helpers for the multiport register file.
package regfile_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned ZERO_ADDR  = 0;

  // Port i occupies [lsb(i, w) +: w] of a flattened read bus.
  function automatic int unsigned bus_lsb(input int unsigned idx, input int unsigned w);
    return idx * w;
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: array lookup, same-cycle bypass, zero-reg mux and busy lookup.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic [DATA_W-1:0] regs [2**ADDR_W],
  input  logic [2**ADDR_W-1:0] busy_vec,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we0,
  input  logic [ADDR_W-1:0] wa0,
  input  logic [DATA_W-1:0] wd0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] wa1,
  input  logic [DATA_W-1:0] wd1,
  output logic [DATA_W-1:0] data,
  output logic              busy
);

  logic is_zero;
  logic hit0;
  logic hit1;

  always_comb begin
    is_zero = ZERO_REG && (addr == ADDR_W'(ZERO_ADDR));
    hit0    = BYPASS && we0 && (wa0 == addr) && !is_zero;
    hit1    = BYPASS && we1 && (wa1 == addr) && !is_zero;

    data = regs[addr];
    if (is_zero)   data = '0;
    else if (hit1) data = wd1;
    else if (hit0) data = wd0;

    // An in-flight writeback to this register hides its pending busy bit.
    busy = busy_vec[addr] && !(hit0 || hit1) && !is_zero;
  end

endmodule

// File: rtl/regfile_multiport.sv
// NREAD-read / 2-write register file with bypass, optional zero register and busy scoreboard.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned NREAD    = 2,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic [NREAD*ADDR_W-1:0] ReadAddr,
  output logic [NREAD*DATA_W-1:0] ReadData,
  output logic [NREAD-1:0]        ReadBusy,
  input  logic                    WriteEn0,
  input  logic [ADDR_W-1:0]       WriteAddr0,
  input  logic [DATA_W-1:0]       WriteData0,
  input  logic                    WriteEn1,
  input  logic [ADDR_W-1:0]       WriteAddr1,
  input  logic [DATA_W-1:0]       WriteData1,
  input  logic                    BusySet,
  input  logic [ADDR_W-1:0]       BusySetAddr
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  if (NREAD < 1 || NREAD > 4) begin : g_bad_nread
    $error("regfile_multiport: NREAD must be in 1..4");
  end

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy_vec;

  logic wr0_ok;
  logic wr1_ok;
  logic set_ok;

  always_comb begin
    wr0_ok = WriteEn0 && !(ZERO_REG && WriteAddr0 == ADDR_W'(ZERO_ADDR));
    wr1_ok = WriteEn1 && !(ZERO_REG && WriteAddr1 == ADDR_W'(ZERO_ADDR));
    set_ok = BusySet  && !(ZERO_REG && BusySetAddr == ADDR_W'(ZERO_ADDR));
  end

  // Port 1 is applied after port 0 so it wins an address conflict.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      if (wr0_ok) regs[WriteAddr0] <= WriteData0;
      if (wr1_ok) regs[WriteAddr1] <= WriteData1;
    end
  end

  // Issue of a new producer outranks the writeback of the old one.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      busy_vec <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (set_ok && BusySetAddr == ADDR_W'(i))
          busy_vec[i] <= 1'b1;
        else if ((WriteEn0 && WriteAddr0 == ADDR_W'(i)) ||
                 (WriteEn1 && WriteAddr1 == ADDR_W'(i)))
          busy_vec[i] <= 1'b0;
      end
    end
  end

  for (genvar g = 0; g < NREAD; g++) begin : g_rd
    regfile_read_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
    ) u_port (
      .regs     (regs),
      .busy_vec (busy_vec),
      .addr     (ReadAddr[bus_lsb(g, ADDR_W) +: ADDR_W]),
      .we0      (WriteEn0),
      .wa0      (WriteAddr0),
      .wd0      (WriteData0),
      .we1      (WriteEn1),
      .wa1      (WriteAddr1),
      .wd1      (WriteData1),
      .data     (ReadData[bus_lsb(g, DATA_W) +: DATA_W]),
      .busy     (ReadBusy[g])
    );
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed bench: a BYPASS=1 and a BYPASS=0 instance share all inputs.
module tb_regfile_multiport;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [9:0]  ReadAddr;
  logic [63:0] rdata_a, rdata_b;
  logic [1:0]  rbusy_a, rbusy_b;
  logic        WriteEn0, WriteEn1, BusySet;
  logic [4:0]  WriteAddr0, WriteAddr1, BusySetAddr;
  logic [31:0] WriteData0, WriteData1;

  int unsigned vecs = 0;
  int unsigned errs = 0;

  always #5 Clock = ~Clock;

  regfile_multiport #(.DATA_W(32), .ADDR_W(5), .NREAD(2), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_a (
    .Clock(Clock), .Reset(Reset), .ReadAddr(ReadAddr), .ReadData(rdata_a), .ReadBusy(rbusy_a),
    .WriteEn0(WriteEn0), .WriteAddr0(WriteAddr0), .WriteData0(WriteData0),
    .WriteEn1(WriteEn1), .WriteAddr1(WriteAddr1), .WriteData1(WriteData1),
    .BusySet(BusySet), .BusySetAddr(BusySetAddr));

  regfile_multiport #(.DATA_W(32), .ADDR_W(5), .NREAD(2), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_b (
    .Clock(Clock), .Reset(Reset), .ReadAddr(ReadAddr), .ReadData(rdata_b), .ReadBusy(rbusy_b),
    .WriteEn0(WriteEn0), .WriteAddr0(WriteAddr0), .WriteData0(WriteData0),
    .WriteEn1(WriteEn1), .WriteAddr1(WriteAddr1), .WriteData1(WriteData1),
    .BusySet(BusySet), .BusySetAddr(BusySetAddr));

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle();
    WriteEn0 = 1'b0; WriteEn1 = 1'b0; BusySet = 1'b0;
  endtask

  task automatic test_reset();
    ReadAddr = {5'd6, 5'd5};
    WriteEn0 = 1'b1; WriteAddr0 = 5'd5; WriteData0 = 32'hDEADBEEF;
    BusySet = 1'b1; BusySetAddr = 5'd6;
    tick(); idle(); #1;
    vecs++; if (rdata_a[31:0] !== 32'hDEADBEEF) begin errs++; $display("FAIL pre_reset_r5 got=%h exp=%h", rdata_a[31:0], 32'hDEADBEEF); end
    vecs++; if (rbusy_b[1] !== 1'b1) begin errs++; $display("FAIL pre_reset_busy6 got=%b exp=1", rbusy_b[1]); end
    // Writes and BusySet during the reset cycle must be ignored.
    Reset = 1'b1;
    WriteEn1 = 1'b1; WriteAddr1 = 5'd5; WriteData1 = 32'hCAFEF00D;
    BusySet = 1'b1; BusySetAddr = 5'd5;
    tick(); Reset = 1'b0; idle(); #1;
    vecs++; if (rdata_a !== 64'h0) begin errs++; $display("FAIL reset_data_a got=%h exp=0", rdata_a); end
    vecs++; if (rdata_b !== 64'h0) begin errs++; $display("FAIL reset_data_b got=%h exp=0", rdata_b); end
    vecs++; if (rbusy_a !== 2'b00 || rbusy_b !== 2'b00) begin errs++; $display("FAIL reset_busy got=%b/%b exp=00/00", rbusy_a, rbusy_b); end
  endtask

  task automatic test_basic();
    ReadAddr = {5'd4, 5'd3};
    WriteEn0 = 1'b1; WriteAddr0 = 5'd3; WriteData0 = 32'h12345678;
    tick(); idle(); #1;
    vecs++; if (rdata_a[31:0] !== 32'h12345678) begin errs++; $display("FAIL basic_r3_a got=%h exp=%h", rdata_a[31:0], 32'h12345678); end
    vecs++; if (rdata_b[31:0] !== 32'h12345678) begin errs++; $display("FAIL basic_r3_b got=%h exp=%h", rdata_b[31:0], 32'h12345678); end
    vecs++; if (rdata_a[63:32] !== 32'h0) begin errs++; $display("FAIL basic_r4 got=%h exp=0", rdata_a[63:32]); end
  endtask

  task automatic test_conflict();
    ReadAddr = {5'd3, 5'd7};
    WriteEn0 = 1'b1; WriteAddr0 = 5'd7; WriteData0 = 32'h1111;
    WriteEn1 = 1'b1; WriteAddr1 = 5'd7; WriteData1 = 32'h2222;
    #1;
    vecs++; if (rdata_a[31:0] !== 32'h2222) begin errs++; $display("FAIL conflict_bypass got=%h exp=%h", rdata_a[31:0], 32'h2222); end
    vecs++; if (rdata_b[31:0] !== 32'h0) begin errs++; $display("FAIL conflict_nobypass got=%h exp=0", rdata_b[31:0]); end
    tick(); idle(); #1;
    vecs++; if (rdata_a[31:0] !== 32'h2222 || rdata_b[31:0] !== 32'h2222) begin errs++; $display("FAIL conflict_stored got=%h/%h exp=2222", rdata_a[31:0], rdata_b[31:0]); end
  endtask

  task automatic test_bypass();
    ReadAddr = {5'd7, 5'd9};
    WriteEn0 = 1'b1; WriteAddr0 = 5'd9; WriteData0 = 32'hA;
    tick(); idle();
    WriteEn0 = 1'b1; WriteAddr0 = 5'd9; WriteData0 = 32'hB;
    #1;
    vecs++; if (rdata_a[31:0] !== 32'hB) begin errs++; $display("FAIL bypass_on got=%h exp=b", rdata_a[31:0]); end
    vecs++; if (rdata_b[31:0] !== 32'hA) begin errs++; $display("FAIL bypass_off got=%h exp=a", rdata_b[31:0]); end
    vecs++; if (rdata_a[63:32] !== 32'h2222) begin errs++; $display("FAIL bypass_other_port got=%h exp=2222", rdata_a[63:32]); end
    tick(); idle(); #1;
    vecs++; if (rdata_b[31:0] !== 32'hB) begin errs++; $display("FAIL bypass_committed got=%h exp=b", rdata_b[31:0]); end
  endtask

  task automatic test_zero_reg();
    ReadAddr = {5'd0, 5'd0};
    WriteEn0 = 1'b1; WriteAddr0 = 5'd0; WriteData0 = 32'hFFFF;
    WriteEn1 = 1'b1; WriteAddr1 = 5'd0; WriteData1 = 32'hFFFF;
    BusySet = 1'b1; BusySetAddr = 5'd0;
    #1;
    vecs++; if (rdata_a !== 64'h0 || rdata_b !== 64'h0) begin errs++; $display("FAIL zero_during_write got=%h/%h exp=0", rdata_a, rdata_b); end
    tick(); idle(); #1;
    vecs++; if (rdata_a !== 64'h0 || rdata_b !== 64'h0) begin errs++; $display("FAIL zero_after_write got=%h/%h exp=0", rdata_a, rdata_b); end
    vecs++; if (rbusy_a !== 2'b00 || rbusy_b !== 2'b00) begin errs++; $display("FAIL zero_busy got=%b/%b exp=00/00", rbusy_a, rbusy_b); end
  endtask

  task automatic test_scoreboard();
    ReadAddr = {5'd13, 5'd12};
    BusySet = 1'b1; BusySetAddr = 5'd12;
    #1;
    vecs++; if (rbusy_a[0] !== 1'b0) begin errs++; $display("FAIL sb_not_yet got=%b exp=0", rbusy_a[0]); end
    tick(); idle(); #1;
    vecs++; if (rbusy_a !== 2'b01 || rbusy_b !== 2'b01) begin errs++; $display("FAIL sb_set got=%b/%b exp=01/01", rbusy_a, rbusy_b); end
    BusySet = 1'b1; BusySetAddr = 5'd12;
    WriteEn1 = 1'b1; WriteAddr1 = 5'd12; WriteData1 = 32'h55;
    #1;
    vecs++; if (rbusy_b[0] !== 1'b1) begin errs++; $display("FAIL sb_nobypass_reg got=%b exp=1", rbusy_b[0]); end
    tick(); idle(); #1;
    vecs++; if (rbusy_a[0] !== 1'b1 || rbusy_b[0] !== 1'b1) begin errs++; $display("FAIL sb_set_wins got=%b/%b exp=1/1", rbusy_a[0], rbusy_b[0]); end
    vecs++; if (rdata_a[31:0] !== 32'h55) begin errs++; $display("FAIL sb_data got=%h exp=55", rdata_a[31:0]); end
    WriteEn0 = 1'b1; WriteAddr0 = 5'd12; WriteData0 = 32'h66;
    #1;
    vecs++; if (rbusy_a[0] !== 1'b0 || rbusy_b[0] !== 1'b1) begin errs++; $display("FAIL sb_writeback_cycle got=%b/%b exp=0/1", rbusy_a[0], rbusy_b[0]); end
    tick(); idle(); #1;
    vecs++; if (rbusy_a !== 2'b00 || rbusy_b !== 2'b00) begin errs++; $display("FAIL sb_cleared got=%b/%b exp=00/00", rbusy_a, rbusy_b); end
  endtask

  initial begin
    Reset = 1'b1; ReadAddr = '0;
    WriteAddr0 = '0; WriteAddr1 = '0; BusySetAddr = '0;
    WriteData0 = '0; WriteData1 = '0;
    idle();
    tick(); tick();
    Reset = 1'b0;
    test_reset();
    test_basic();
    test_conflict();
    test_bypass();
    test_zero_reg();
    test_scoreboard();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
